// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_unit
// Purpose  : RV32I integer execute unit.  Each issued instruction is evaluated
//            combinationally in the issue cycle, and its result is written into
//            a small result queue.  The queue head is broadcast on the common
//            data bus until the bus arbiter grants it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   1   rising-edge clock
//   rst_n           in   1   asynchronous active-low reset
//   rdy             in   1   global enable; low freezes every register
//   rollback        in   1   synchronous flush of all queued results
//   in_config       in   1   issue valid
//   in_value_1      in  32   rs1 operand
//   in_value_2      in  32   rs2 operand
//   in_value_pc     in  32   PC of the issued instruction
//   in_opcode       in   7   major opcode
//   in_precise      in   3   funct3
//   in_more_precise in   1   funct7[5] (SUB / SRA / SRAI)
//   in_imm          in  32   sign-extended immediate
//   in_rob_entry    in   4   reorder-buffer tag
//   cdb_grant       in   1   head result accepted by the bus this cycle
//   out_config      out  1   result valid (queue non-empty)
//   out_val         out 32   result value
//   out_rob_entry   out  4   result tag
//   out_jump        out  1   control-flow redirect taken
//   out_target      out 32   next PC
//   out_stall       out  1   issuer must not send next cycle
//   out_overflow    out  1   sticky: an issue was dropped on a full queue
// ============================================================================
module alu_unit #(
  parameter int DEPTH = 4  // result-queue entries, power of two, >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        in_config,
  input  logic [31:0] in_value_1,
  input  logic [31:0] in_value_2,
  input  logic [31:0] in_value_pc,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_precise,
  input  logic        in_more_precise,
  input  logic [31:0] in_imm,
  input  logic [3:0]  in_rob_entry,
  input  logic        cdb_grant,
  output logic        out_config,
  output logic [31:0] out_val,
  output logic [3:0]  out_rob_entry,
  output logic        out_jump,
  output logic [31:0] out_target,
  output logic        out_stall,
  output logic        out_overflow
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // --------------------------------------------------------------------------
  // Execute datapath (purely combinational on the issue-side inputs)
  // --------------------------------------------------------------------------
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] alu_res;
  logic        br_taken;
  logic [31:0] res_val;
  logic        res_jump;
  logic [31:0] res_target;

  // Second ALU operand is rs2 for register-register ops, the immediate
  // otherwise; only its low five bits ever act as a shift amount.
  assign op_b        = (in_opcode == OPC_OP) ? in_value_2 : in_imm;
  assign shamt       = op_b[4:0];
  assign pc_plus4    = in_value_pc + 32'd4;
  assign pc_plus_imm = in_value_pc + in_imm;

  // Shared integer ALU for OP and OP-IMM.
  always_comb begin
    alu_res = 32'd0;
    case (in_precise)
      3'b000: begin
        // There is no SUBI: funct7[5] only selects subtraction for OP.
        if ((in_opcode == OPC_OP) && in_more_precise) begin
          alu_res = in_value_1 - op_b;
        end else begin
          alu_res = in_value_1 + op_b;
        end
      end
      3'b001: alu_res = in_value_1 << shamt;
      3'b010: alu_res = {31'd0, ($signed(in_value_1) < $signed(op_b))};
      3'b011: alu_res = {31'd0, (in_value_1 < op_b)};
      3'b100: alu_res = in_value_1 ^ op_b;
      3'b101: begin
        if (in_more_precise) begin
          alu_res = 32'($signed(in_value_1) >>> shamt);
        end else begin
          alu_res = in_value_1 >> shamt;
        end
      end
      3'b110: alu_res = in_value_1 | op_b;
      3'b111: alu_res = in_value_1 & op_b;
      default: alu_res = 32'd0;
    endcase
  end

  // Branch condition evaluation (funct3 010/011 are not branches: never taken).
  always_comb begin
    br_taken = 1'b0;
    case (in_precise)
      3'b000:  br_taken = (in_value_1 == in_value_2);
      3'b001:  br_taken = (in_value_1 != in_value_2);
      3'b100:  br_taken = ($signed(in_value_1) <  $signed(in_value_2));
      3'b101:  br_taken = ($signed(in_value_1) >= $signed(in_value_2));
      3'b110:  br_taken = (in_value_1 <  in_value_2);
      3'b111:  br_taken = (in_value_1 >= in_value_2);
      default: br_taken = 1'b0;
    endcase
  end

  // Result selection per opcode.  Non-redirecting instructions always report
  // the fall-through PC as their target.
  always_comb begin
    res_val    = 32'd0;
    res_jump   = 1'b0;
    res_target = pc_plus4;
    case (in_opcode)
      OPC_OP, OPC_OP_IMM: res_val = alu_res;
      OPC_LUI:            res_val = in_imm;
      OPC_AUIPC:          res_val = pc_plus_imm;
      OPC_JAL: begin
        res_val    = pc_plus4;
        res_jump   = 1'b1;
        res_target = pc_plus_imm;
      end
      OPC_JALR: begin
        res_val    = pc_plus4;
        res_jump   = 1'b1;
        res_target = (in_value_1 + in_imm) & ~32'd1;
      end
      OPC_BRANCH: begin
        res_jump   = br_taken;
        res_target = br_taken ? pc_plus_imm : pc_plus4;
      end
      default: begin
        res_val    = 32'd0;
        res_jump   = 1'b0;
        res_target = pc_plus4;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Result queue control
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             q_empty;
  logic             q_full;
  logic             flush;
  logic             do_pop;
  logic             do_push;
  logic             do_drop;

  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == CNT_FULL);
  assign flush   = rdy & rollback;

  // A pop frees the head slot at the same edge, so a full queue can still
  // accept an issue when the bus takes the head simultaneously.
  assign do_pop  = rdy & ~rollback & ~q_empty & cdb_grant;
  assign do_push = rdy & ~rollback & in_config & (~q_full | do_pop);
  assign do_drop = rdy & ~rollback & in_config & q_full & ~do_pop;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (do_pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (do_drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Result queue storage
  // --------------------------------------------------------------------------
  logic [31:0] val_q    [DEPTH];
  logic [3:0]  rob_q    [DEPTH];
  logic        jump_q   [DEPTH];
  logic [31:0] target_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i]    <= 32'd0;
        rob_q[i]    <= 4'd0;
        jump_q[i]   <= 1'b0;
        target_q[i] <= 32'd0;
      end
    end else if (do_push) begin
      val_q[tail_q]    <= res_val;
      rob_q[tail_q]    <= in_rob_entry;
      jump_q[tail_q]   <= res_jump;
      target_q[tail_q] <= res_target;
    end
  end

  // --------------------------------------------------------------------------
  // Broadcast outputs: head entry, forced to zero while the queue is empty so
  // stale entries never appear on the bus.
  // --------------------------------------------------------------------------
  assign out_config    = ~q_empty;
  assign out_val       = q_empty ? 32'd0 : val_q[head_q];
  assign out_rob_entry = q_empty ? 4'd0  : rob_q[head_q];
  assign out_jump      = q_empty ? 1'b0  : jump_q[head_q];
  assign out_target    = q_empty ? 32'd0 : target_q[head_q];
  assign out_stall     = (count_q >= CNT_STALL);
  assign out_overflow  = overflow_q;

endmodule
`default_nettype wire

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low freezes all state.
- rollback  in  1  synchronous flush.
REQ-002 SHALL take issue-side inputs from the reservation station:
- in_config 1
- in_value_1 32
- in_value_2 32
- in_value_pc 32
- in_opcode 7
- in_precise 3 (funct3)
- in_more_precise 1 (funct7[5])
- in_imm 32
- in_rob_entry 4
REQ-003 SHALL drive result-broadcast outputs:
- out_config 1 (result valid)
- out_val 32
- out_rob_entry 4
- out_jump 1 (redirect taken)
- out_target 32 (next PC)
REQ-004 SHALL have cdb_grant  in  1: broadcast accepted this cycle.
REQ-005 SHALL have out_stall  out  1: issuer must not send the next cycle.
REQ-006 SHALL have out_overflow  out  1: sticky, an issue was dropped.
REQ-007 SHALL have parameter DEPTH, default 4, result-queue entries (power of two).

Function
REQ-008 SHALL, on in_config=1, rdy=1, rollback=0 at a rising edge, compute the result combinationally and write {val, rob_entry, jump, target} into the queue tail at that edge.
REQ-009 SHALL compute OP (0110011) as value_1 op value_2, with op selected by funct3 plus more_precise (SUB, SRA).
REQ-010 SHALL compute OP-IMM (0010011) as value_1 op imm; shift amount imm[4:0]; more_precise selects SRAI; no SUBI.
REQ-011 SHALL compute shifts and SLT/SLTU per RV32I, using only operand bits [4:0] as the shift amount.
REQ-012 SHALL compute LUI val=imm and AUIPC val=pc+imm, both with jump=0 and target=pc+4.
REQ-013 SHALL compute JAL val=pc+4, jump=1, target=pc+imm.
REQ-014 SHALL compute JALR val=pc+4, jump=1, target=(value_1+imm)&~1.
REQ-015 SHALL compute BRANCH (1100011) taken per funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU) on value_1 vs value_2; jump=taken; target=taken?pc+imm:pc+4; val=0.
REQ-016 SHALL, for any other opcode, enqueue val=0, jump=0, target=pc+4.
REQ-017 SHALL do all arithmetic modulo 2^32 with no overflow indication.
REQ-018 SHALL drive out_config = queue non-empty, with out_val/out_rob_entry/out_jump/out_target taken combinationally from the head entry.
REQ-019 SHALL give latency of exactly one cycle: a result accepted at edge N is visible on the outputs from edge N until it is popped.
REQ-020 SHALL pop the head at an edge where out_config=1, cdb_grant=1 and rdy=1; cdb_grant is ignored while empty.
REQ-021 SHALL, on simultaneous push and pop, perform both, leaving count unchanged, including when count=DEPTH.
REQ-022 SHALL drive out_stall = (count >= DEPTH-1), combinationally from the registered count.
REQ-023 SHALL drop an issue arriving when count=DEPTH with no pop, set out_overflow, and leave the queue unchanged.
REQ-024 SHALL wrap head/tail pointers modulo DEPTH, with count tracked separately (0..DEPTH).
REQ-025 SHALL, on rollback=1 at an edge (with rdy=1), empty the queue, ignore in_config and cdb_grant that cycle, and leave out_overflow unchanged.
REQ-026 SHALL, with rdy=0, neither push, pop nor flush, and hold the outputs stable.

Reset
REQ-027 SHALL, on rst_n low, immediately clear pointers, count and out_overflow; out_config=0 and out_stall=0 while reset is held.
REQ-028 SHALL hold out_val, out_rob_entry, out_jump and out_target at 0 while empty after reset.
REQ-029 SHALL let reset asserted mid-operation discard all queued results without waiting for a clock edge.
REQ-030 SHALL accept the first issue at the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL cover ADD then SUB: OP, v1=7, v2=5, more_precise=0, rob=3 -> next cycle out_config=1, val=12, rob=3, jump=0; same with more_precise=1 -> val=2.
REQ-032 SHALL cover BLT signed: v1=0xFFFFFFFF, v2=1, pc=0x100, imm=0x20 -> jump=1, target=0x120; BLTU with the same operands -> jump=0, target=0x104.
REQ-033 SHALL cover JALR: pc=0x40, v1=0x1001, imm=2 -> val=0x44, jump=1, target=0x1002.
REQ-034 SHALL cover backpressure: cdb_grant=0 with issues on 3 consecutive cycles -> out_stall=1 after the 3rd; a 5th issue with no grant -> out_overflow=1 and count stays 4; then grant for 4 cycles -> results emerge in FIFO order, out_stall drops once count=2.
REQ-035 SHALL cover flush: 2 queued entries with rollback plus in_config in the same cycle -> next cycle out_config=0 and count=0.
REQ-036 SHALL cover async reset: rst_n pulsed low between edges with 3 queued entries -> out_config=0 immediately, out_overflow=0.
